// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse crossing scheduler: FSM encoding and
// elaboration-time sizing/consistency helpers.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  // Gap counter must hold P_GAP-2; never narrower than one bit.
  function automatic int gap_cnt_w(input int gap);
    return (gap > 2) ? $clog2(gap) : 1;
  endfunction

  function automatic bit idw_ok(input int n, input int idw);
    return (n >= 2) && (n <= 16) && (idw == $clog2(n));
  endfunction

endpackage

// File: rtl/pulse_sched_rr_arb.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping from P_N-1 back to 0.
module pulse_sched_rr_arb #(
  parameter int P_N   = 4,
  parameter int P_IDW = 2
) (
  input  logic [P_N-1:0]   i_req,
  input  logic [P_IDW-1:0] i_ptr,
  output logic             o_vld,
  output logic [P_IDW-1:0] o_idx
);

  int w_j;

  // Scan from the farthest offset down so the closest match is written last.
  always_comb begin
    o_vld = 1'b0;
    o_idx = '0;
    w_j   = 0;
    for (int k = P_N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= P_N) w_j = w_j - P_N;
      if (i_req[w_j[P_IDW-1:0]]) begin
        o_vld = 1'b1;
        o_idx = w_j[P_IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/pulse_xfer_sched.sv
// Round-robin scheduler sharing one toggle-based pulse crossing among P_N requesters.
// Define PULSE_SCHED_CNT_EN for saturating per-requester counters instead of 1-bit flags.
module pulse_xfer_sched
  import pulse_sched_pkg::*;
#(
  parameter int P_N   = 4,
  parameter int P_IDW = 2,
  parameter int P_GAP = 6,
  parameter int P_CW  = 4
) (
  input  logic             CLK_I,
  input  logic             RST,
  input  logic [P_N-1:0]   REQ_I,
  input  logic [P_N-1:0]   MASK_I,
  input  logic             DROP_CLR_I,
  output logic             PULSE_O,
  output logic [P_IDW-1:0] SEL_O,
  output logic [P_N-1:0]   PEND_O,
  output logic [P_N-1:0]   DROP_O,
  output logic             IDLE_O
);

  localparam int            GW       = gap_cnt_w(P_GAP);
  localparam logic [GW-1:0] GAP_LOAD = GW'(P_GAP - 2);
  localparam bit            CFG_OK   = idw_ok(P_N, P_IDW) && (P_GAP >= 2) && (P_CW >= 1);

  if (!CFG_OK) begin : g_cfg_err
    $error("pulse_xfer_sched: inconsistent P_N/P_IDW/P_GAP/P_CW");
  end

  state_e           r_state, w_state_nxt;
  logic [GW-1:0]    r_gap;
  logic [P_IDW-1:0] r_sel, r_ptr;
  logic [P_N-1:0]   r_drop;
  logic [P_N-1:0]   w_pend, w_elig, w_drop_evt, w_iss_vec;
  logic             w_arb_vld, w_grant, w_issue;
  logic [P_IDW-1:0] w_arb_idx;

  assign w_elig = w_pend & MASK_I;

  pulse_sched_rr_arb #(
    .P_N   (P_N),
    .P_IDW (P_IDW)
  ) u_arb (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_vld (w_arb_vld),
    .o_idx (w_arb_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = (GAP_LOAD == '0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        // Leave as the count reaches zero so issue-to-issue spacing is exactly P_GAP.
        if (r_gap <= GW'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) r_sel <= w_arb_idx;
      if (w_issue) begin
        r_ptr <= (r_sel == P_IDW'(P_N - 1)) ? '0 : r_sel + P_IDW'(1);
        r_gap <= GAP_LOAD;
      end else if ((r_state == S_GAP) && (r_gap != '0)) begin
        r_gap <= r_gap - GW'(1);
      end
    end
  end

  always_comb begin
    w_iss_vec = '0;
    for (int i = 0; i < P_N; i++) begin
      w_iss_vec[i] = w_issue && (r_sel == P_IDW'(i));
    end
  end

`ifdef PULSE_SCHED_CNT_EN
  // A request meeting its own issue is accepted even at max: the slot is freed that cycle.
  for (genvar gi = 0; gi < P_N; gi++) begin : g_cnt
    logic [P_CW-1:0] r_cnt;
    logic            w_full, w_inc, w_dec;

    assign w_full          = &r_cnt;
    assign w_dec           = w_iss_vec[gi];
    assign w_inc           = REQ_I[gi] && (!w_full || w_dec);
    assign w_drop_evt[gi]  = REQ_I[gi] && w_full && !w_dec;
    assign w_pend[gi]      = |r_cnt;

    always_ff @(posedge CLK_I) begin
      if (RST) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + P_CW'(1);
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - P_CW'(1);
      end
    end
  end
`else
  logic [P_N-1:0] r_pend;

  assign w_pend     = r_pend;
  assign w_drop_evt = REQ_I & r_pend & ~w_iss_vec;

  always_ff @(posedge CLK_I) begin
    if (RST) r_pend <= '0;
    else     r_pend <= (r_pend & ~w_iss_vec) | REQ_I;
  end
`endif

  // Set wins over clear so a drop coinciding with DROP_CLR_I is never lost.
  always_ff @(posedge CLK_I) begin
    if (RST) r_drop <= '0;
    else     r_drop <= (r_drop & ~{P_N{DROP_CLR_I}}) | w_drop_evt;
  end

  assign PULSE_O = w_issue;
  assign SEL_O   = r_sel;
  assign PEND_O  = w_pend;
  assign DROP_O  = r_drop;
  assign IDLE_O  = (r_state == S_IDLE) && !w_arb_vld;

endmodule

// File: tb/tb_pulse_xfer_sched.sv
// Self-checking bench for pulse_xfer_sched: directed scenarios plus random traffic
// against a cycle-level behavioural model of the scheduling rules.
module tb_pulse_xfer_sched;

  localparam int P_N   = 4;
  localparam int P_IDW = 2;
  localparam int P_GAP = 6;
  localparam int P_CW  = 2;
  localparam int MAXC  = (1 << P_CW) - 1;
`ifdef PULSE_SCHED_CNT_EN
  localparam bit CNT_MODE = 1'b1;
`else
  localparam bit CNT_MODE = 1'b0;
`endif

  logic             CLK_I;
  logic             RST;
  logic [P_N-1:0]   REQ_I;
  logic [P_N-1:0]   MASK_I;
  logic             DROP_CLR_I;
  logic             PULSE_O;
  logic [P_IDW-1:0] SEL_O;
  logic [P_N-1:0]   PEND_O;
  logic [P_N-1:0]   DROP_O;
  logic             IDLE_O;

  pulse_xfer_sched #(
    .P_N   (P_N),
    .P_IDW (P_IDW),
    .P_GAP (P_GAP),
    .P_CW  (P_CW)
  ) dut (
    .CLK_I      (CLK_I),
    .RST        (RST),
    .REQ_I      (REQ_I),
    .MASK_I     (MASK_I),
    .DROP_CLR_I (DROP_CLR_I),
    .PULSE_O    (PULSE_O),
    .SEL_O      (SEL_O),
    .PEND_O     (PEND_O),
    .DROP_O     (DROP_O),
    .IDLE_O     (IDLE_O)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  int errors = 0;
  int checks = 0;
  int tcyc   = 0;
  int log_cyc[$];
  int log_sel[$];

  // Reference model: pending amounts, sticky drops, last issue time, grant pipeline.
  int       m_cnt[P_N];
  logic [P_N-1:0] m_drop;
  int       m_sel, m_ptr, m_last, m_cyc;
  bit       m_granted, m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [P_N-1:0] mask);
    for (int k = 0; k < P_N; k++) begin
      int j;
      j = (m_ptr + k) % P_N;
      if (m_cnt[j] != 0 && mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_adv(input logic rst, input logic [P_N-1:0] req,
                           input logic [P_N-1:0] mask, input logic clr);
    int pick, isel;
    bit can_grant;
    logic [P_N-1:0] dev;
    if (rst) begin
      for (int i = 0; i < P_N; i++) m_cnt[i] = 0;
      m_drop = '0; m_sel = 0; m_ptr = 0; m_granted = 0;
      m_cyc = 0; m_last = -1000; m_valid = 1;
      return;
    end
    pick      = model_pick(mask);
    can_grant = !m_granted && (m_cyc - m_last >= P_GAP - 1) && (pick >= 0);
    isel      = m_granted ? m_sel : -1;
    dev       = '0;
    for (int i = 0; i < P_N; i++) begin
      bit iss;
      iss = (i == isel);
      if (CNT_MODE) begin
        if (req[i]) begin
          if (m_cnt[i] == MAXC && !iss) dev[i] = 1'b1;
          else if (!iss) m_cnt[i]++;
        end else if (iss) m_cnt[i]--;
      end else begin
        if (req[i]) begin
          if (m_cnt[i] != 0 && !iss) dev[i] = 1'b1;
          m_cnt[i] = 1;
        end else if (iss) m_cnt[i] = 0;
      end
    end
    m_drop = (clr ? '0 : m_drop) | dev;
    if (m_granted) begin
      m_ptr  = (m_sel + 1) % P_N;
      m_last = m_cyc;
    end
    m_granted = can_grant;
    if (can_grant) m_sel = pick;
    m_cyc++;
  endtask

  task automatic step(input logic rst, input logic [P_N-1:0] req,
                      input logic [P_N-1:0] mask, input logic clr);
    logic [P_N-1:0] epend;
    bit eidle;
    RST = rst; REQ_I = req; MASK_I = mask; DROP_CLR_I = clr;
    #1;
    if (m_valid) begin
      for (int i = 0; i < P_N; i++) epend[i] = (m_cnt[i] != 0);
      eidle = !m_granted && (m_cyc - m_last >= P_GAP - 1) && ((epend & mask) == '0);
      chk("pulse", 32'(PULSE_O), 32'(m_granted));
      chk("sel",   32'(SEL_O),   32'(m_sel));
      chk("pend",  32'(PEND_O),  32'(epend));
      chk("drop",  32'(DROP_O),  32'(m_drop));
      chk("idle",  32'(IDLE_O),  32'(eidle));
      if (PULSE_O === 1'b1) begin
        log_cyc.push_back(tcyc);
        log_sel.push_back(int'(SEL_O));
      end
    end
    model_adv(rst, req, mask, clr);
    tcyc = rst ? 0 : tcyc + 1;
    @(negedge CLK_I);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '1, 1'b0);
    log_cyc.delete();
    log_sel.delete();
  endtask

  task automatic idle_steps(input int n, input logic [P_N-1:0] mask);
    for (int i = 0; i < n; i++) step(1'b0, '0, mask, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t2_cyc[4] = '{2, 8, 14, 20};
    int t5_n;
    m_valid = 0;
    RST = 1'b1; REQ_I = '0; MASK_I = '1; DROP_CLR_I = 1'b0;
    @(negedge CLK_I);

    // Single request after a 3-cycle reset: pulse two cycles later on channel 0.
    do_reset(3);
    chk("rst_idle", 32'(IDLE_O), 32'd1);
    chk("rst_pend", 32'(PEND_O), 32'd0);
    idle_steps(10, '1);
    step(1'b0, 4'b0001, '1, 1'b0);
    idle_steps(10, '1);
    chk("t1_npulse", 32'(log_cyc.size()), 32'd1);
    chk("t1_cyc", 32'(log_cyc.size() > 0 ? log_cyc[0] : -1), 32'd12);
    chk("t1_sel", 32'(log_sel.size() > 0 ? log_sel[0] : -1), 32'd0);

    // All four at once: round-robin order, P_GAP spacing.
    do_reset(1);
    step(1'b0, 4'b1111, '1, 1'b0);
    idle_steps(24, '1);
    chk("t2_npulse", 32'(log_cyc.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("t2_cyc", 32'(k < log_cyc.size() ? log_cyc[k] : -1), 32'(t2_cyc[k]));
      chk("t2_sel", 32'(k < log_sel.size() ? log_sel[k] : -1), 32'(k));
    end

    // Masked requester accumulates but is not granted until unmasked.
    do_reset(1);
    step(1'b0, 4'b0010, 4'b1101, 1'b0);
    idle_steps(6, 4'b1101);
    chk("t3_nopulse", 32'(log_cyc.size()), 32'd0);
    chk("t3_pend", 32'(PEND_O), 32'b0010);
    idle_steps(6, '1);
    chk("t3_npulse", 32'(log_cyc.size()), 32'd1);
    chk("t3_sel", 32'(log_sel.size() > 0 ? log_sel[0] : -1), 32'd1);

    // Repeated request while pending; then clear the sticky drop.
    do_reset(1);
    step(1'b0, 4'b0100, 4'b1011, 1'b0);
    step(1'b0, 4'b0100, 4'b1011, 1'b0);
    step(1'b0, 4'b0000, 4'b1011, 1'b0);
    chk("t4_drop", 32'(DROP_O), CNT_MODE ? 32'd0 : 32'b0100);
    idle_steps(16, '1);
    chk("t4_npulse", 32'(log_cyc.size()), CNT_MODE ? 32'd2 : 32'd1);
    step(1'b0, '0, '1, 1'b1);
    step(1'b0, '0, '1, 1'b0);
    chk("t4_clr", 32'(DROP_O), 32'd0);

    // Five requests while masked: saturation (counter) or coalescing (flag).
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0001, 4'b1110, 1'b0);
    chk("t5_drop", 32'(DROP_O), 32'b0001);
    idle_steps(24, '1);
    t5_n = CNT_MODE ? MAXC : 1;
    chk("t5_npulse", 32'(log_cyc.size()), 32'(t5_n));
    for (int k = 1; k < log_cyc.size(); k++)
      chk("t5_space", 32'(log_cyc[k] - log_cyc[k-1]), 32'(P_GAP));

    // Reset mid-gap with pending 0110 aborts everything.
    do_reset(1);
    step(1'b0, 4'b0010, '1, 1'b0);
    step(1'b0, 4'b0000, '1, 1'b0);
    step(1'b0, 4'b0000, '1, 1'b0);
    step(1'b0, 4'b0110, '1, 1'b0);
    chk("t6_pre_sel", 32'(SEL_O), 32'd1);
    step(1'b1, 4'b0000, '1, 1'b0);
    chk("t6_pend", 32'(PEND_O), 32'd0);
    chk("t6_sel", 32'(SEL_O), 32'd0);
    log_cyc.delete();
    idle_steps(12, '1);
    chk("t6_nopulse", 32'(log_cyc.size()), 32'd0);

    // Random traffic against the model.
    do_reset(2);
    begin
      logic [P_N-1:0] rq, mk;
      logic cl, rs;
      mk = '1;
      for (int n = 0; n < 1500; n++) begin
        for (int i = 0; i < P_N; i++) rq[i] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) mk = P_N'($urandom);
        cl = ($urandom_range(0, 15) == 0);
        rs = ($urandom_range(0, 199) == 0);
        step(rs, rq, mk, cl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
